// File: rtl/passenger_stream_fifo.sv
// ============================================================================
// passenger_stream_fifo
//
// Passenger queue controller with built-in storage. A byte stream arrives over
// a valid/ready handshake and each symbol is classified as it is accepted:
// luggage digits are thrown away, the end sign closes the input phase, and
// every other symbol is a passenger that is stored. Once input is closed the
// stored passengers drain over a valid/ready output. After the last one leaves,
// done_fifo rises and stays high until the next reset.
//
// Optional feature macro: LIFO_EN
//   defined   - storage behaves as a stack and passengers drain newest-first
//   undefined - storage behaves as a FIFO and passengers drain oldest-first
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset; discards all stored data
//   ready_fifo  start request, latched on the first clock edge that sees it high
//   in_valid    data_in carries a symbol this cycle
//   data_in     input symbol
//   in_ready    block accepts data_in this cycle (only while filling)
//   out_valid   data_out holds a passenger (only while draining)
//   out_ready   downstream takes data_out this cycle
//   data_out    head entry, read combinationally from storage (show-ahead)
//   count       number of stored entries
//   overflow    sticky: a passenger was dropped because storage was full
//   done_fifo   drain complete; held until reset
// ============================================================================
module passenger_stream_fifo #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    DEPTH      = 16,
   parameter logic [DATA_WIDTH-1:0] END_SIGN   = 8'h24,
   parameter logic [DATA_WIDTH-1:0] LUG_MIN    = 8'd49,
   parameter logic [DATA_WIDTH-1:0] LUG_MAX    = 8'd57
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       ready_fifo,
   input  logic                       in_valid,
   input  logic [DATA_WIDTH-1:0]      data_in,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       done_fifo
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DRAIN,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic                  started;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
`ifndef LIFO_EN
   logic [PTR_W-1:0]      rd_ptr;
`endif

   logic is_luggage;
   logic is_end;
   logic push;
   logic pop;
   logic drop_full;

   // Pointers wrap explicitly so DEPTH does not have to be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
      return (p == '0) ? LAST_IDX : p - PTR_W'(1);
   endfunction

   // Symbol classification is purely combinational on the incoming byte.
   always_comb begin
      is_luggage = (data_in >= LUG_MIN) && (data_in <= LUG_MAX);
      is_end     = (data_in == END_SIGN);
   end

   // Start latch and state register. The latch is sticky so a one-cycle
   // ready_fifo pulse is enough to start the controller.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         started <= 1'b0;
      end else begin
         state <= state_next;
         if (ready_fifo) begin
            started <= 1'b1;
         end
      end
   end

   // Next-state and handshake decode. An end sign with nothing stored skips
   // DRAIN entirely so an empty stream finishes one cycle after the end sign;
   // with passengers stored, DRAIN's own empty check adds the extra cycle.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      drop_full  = 1'b0;
      case (state)
         IDLE: begin
            if (started) begin
               state_next = FILL;
            end
         end
         FILL: begin
            in_ready = 1'b1;
            if (in_valid && !is_luggage) begin
               if (is_end) begin
                  state_next = (count == '0) ? DONE : DRAIN;
               end else if (count != FULL_CNT) begin
                  push = 1'b1;
               end else begin
                  drop_full = 1'b1;
               end
            end
         end
         DRAIN: begin
            out_valid = (count != '0);
            pop       = out_valid && out_ready;
            if (count == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = DONE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign done_fifo = (state == DONE);

   // Pointer, occupancy and overflow bookkeeping. Push only happens in FILL
   // and pop only in DRAIN, so the two never collide.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
`ifndef LIFO_EN
         rd_ptr   <= '0;
`endif
         count    <= '0;
         overflow <= 1'b0;
      end else begin
`ifdef LIFO_EN
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end else if (pop) begin
            wr_ptr <= ptr_dec(wr_ptr);
         end
`else
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
`endif
         if (push) begin
            count <= count + CNT_W'(1);
         end else if (pop) begin
            count <= count - CNT_W'(1);
         end
         if (drop_full) begin
            overflow <= 1'b1;
         end
      end
   end

   // Storage array. Contents need no reset: count and the pointers define
   // which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Show-ahead read of the entry that the next pop will remove.
`ifdef LIFO_EN
   assign data_out = mem[ptr_dec(wr_ptr)];
`else
   assign data_out = mem[rd_ptr];
`endif

endmodule
